// File: rtl/div_if.sv
// Request/response bundle between the EX-stage issuer and the iterative divider.
// The master drives operands and consumes results; the slave is the divider itself.
interface div_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] src1;
  logic [N-1:0] src2;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] res;
  logic         div_zero;

  modport master (
    output in_valid, src1, src2, op, out_ready,
    input  in_ready, out_valid, res, div_zero
  );

  modport slave (
    input  in_valid, src1, src2, op, out_ready,
    output in_ready, out_valid, res, div_zero
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Operands are reduced to magnitudes at accept; signs are reapplied on the final iteration.
module div_unit #(
  parameter int N = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush,
  div_if.slave  bus
);

  localparam int             CW   = $clog2(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);
  localparam logic [N-1:0]   ONES = {N{1'b1}};
  localparam logic [N-1:0]   ZERO = {N{1'b0}};
  localparam logic [N-1:0]   MIN  = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [N-1:0] neg_f(input logic [N-1:0] x);
    return ~x + {{(N-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [N-1:0] cond_neg_f(input logic [N-1:0] x, input logic neg);
    return neg ? neg_f(x) : x;
  endfunction

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [N-1:0]  dvd_r;
  logic [N-1:0]  dvs_r;
  logic [N-1:0]  rem_r;
  logic [N-1:0]  res_r;
  logic          sel_rem_r;
  logic          neg_q_r;
  logic          neg_r_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic          div_zero_r;

  logic          signed_s;
  logic [N-1:0]  abs1_s;
  logic [N-1:0]  abs2_s;
  logic          zero_s;
  logic          ovf_s;
  logic [N:0]    trial_s;
  logic [N-1:0]  next_rem_s;
  logic [N-1:0]  next_quo_s;

  assign signed_s = ~bus.op[0];
  assign abs1_s   = cond_neg_f(bus.src1, signed_s & bus.src1[N-1]);
  assign abs2_s   = cond_neg_f(bus.src2, signed_s & bus.src2[N-1]);
  assign zero_s   = (bus.src2 == ZERO);
  assign ovf_s    = signed_s & (bus.src1 == MIN) & (bus.src2 == ONES);

  // The quotient shifts into the dividend register as the dividend bits shift out.
  assign trial_s    = {rem_r, dvd_r[N-1]} - {1'b0, dvs_r};
  assign next_rem_s = trial_s[N] ? {rem_r[N-2:0], dvd_r[N-1]} : trial_s[N-1:0];
  assign next_quo_s = {dvd_r[N-2:0], ~trial_s[N]};

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.res       = res_r;
  assign bus.div_zero  = div_zero_r;

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      dvd_r       <= ZERO;
      dvs_r       <= ZERO;
      rem_r       <= ZERO;
      res_r       <= ZERO;
      sel_rem_r   <= 1'b0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      div_zero_r  <= 1'b0;
    end else if (flush) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            sel_rem_r  <= bus.op[1];
            neg_q_r    <= signed_s & (bus.src1[N-1] ^ bus.src2[N-1]);
            neg_r_r    <= signed_s & bus.src1[N-1];
            dvd_r      <= abs1_s;
            dvs_r      <= abs2_s;
            rem_r      <= ZERO;
            cnt_r      <= {CW{1'b0}};
            in_ready_r <= 1'b0;
            if (zero_s) begin
              res_r       <= bus.op[1] ? bus.src1 : ONES;
              div_zero_r  <= 1'b1;
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end else if (ovf_s) begin
              res_r       <= bus.op[1] ? ZERO : bus.src1;
              div_zero_r  <= 1'b0;
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end else begin
              state_r <= CALC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          if (cnt_r == LAST) begin
            res_r       <= sel_rem_r ? cond_neg_f(next_rem_s, neg_r_r)
                                     : cond_neg_f(next_quo_s, neg_q_r);
            div_zero_r  <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            rem_r <= next_rem_s;
            dvd_r <= next_quo_s;
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed, table-driven bench for div_unit: result values, div_zero, latency, and
// hand-written sequences for backpressure, flush and mid-operation reset.
module tb_div_unit;

  logic clk;
  logic rst_n;
  logic flush;
  int   total;
  int   bad;

  div_if #(.N(32)) bus ();

  div_unit #(.N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_dz;
    int          exp_lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    while (!bus.in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    bus.op       = op;
    bus.src1     = a;
    bus.src2     = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.src1     = $urandom;
    bus.src2     = $urandom;
    bus.op       = ~op;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    int          seen;
    logic [31:0] r;

    total = 0;
    bad   = 0;

    vecs[0]  = '{"divu_100_7",   2'b01, 32'd100,        32'd7,          32'd14,         1'b0, 33};
    vecs[1]  = '{"remu_100_7",   2'b11, 32'd100,        32'd7,          32'd2,          1'b0, 33};
    vecs[2]  = '{"div_m7_2",     2'b00, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   1'b0, 33};
    vecs[3]  = '{"rem_m7_2",     2'b10, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   1'b0, 33};
    vecs[4]  = '{"div_7_m2",     2'b00, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   1'b0, 33};
    vecs[5]  = '{"rem_7_m2",     2'b10, 32'd7,          32'hFFFFFFFE,   32'd1,          1'b0, 33};
    vecs[6]  = '{"div_5_0",      2'b00, 32'd5,          32'd0,          32'hFFFFFFFF,   1'b1, 1};
    vecs[7]  = '{"rem_5_0",      2'b10, 32'd5,          32'd0,          32'd5,          1'b1, 1};
    vecs[8]  = '{"div_ovf",      2'b00, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b0, 1};
    vecs[9]  = '{"rem_ovf",      2'b10, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b0, 1};
    vecs[10] = '{"divu_min_ones",2'b01, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b0, 33};
    vecs[11] = '{"remu_min_ones",2'b11, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b0, 33};
    vecs[12] = '{"div_m100_m7",  2'b00, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         1'b0, 33};
    vecs[13] = '{"rem_m100_m7",  2'b10, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   1'b0, 33};
    vecs[14] = '{"divu_max_16",  2'b01, 32'hFFFFFFFF,   32'd16,         32'h0FFFFFFF,   1'b0, 33};
    vecs[15] = '{"remu_max_16",  2'b11, 32'hFFFFFFFF,   32'd16,         32'd15,         1'b0, 33};

    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.src1      = 32'd0;
    bus.src2      = 32'd0;
    bus.op        = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_res",       bus.res,                32'd0);
    check("reset_div_zero",  {31'd0, bus.div_zero},  32'd0);

    for (int i = 0; i < 16; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_out(lat);
      check({vecs[i].name, "_res"}, bus.res, vecs[i].exp_res);
      check({vecs[i].name, "_dz"},  {31'd0, bus.div_zero}, {31'd0, vecs[i].exp_dz});
      check({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
      consume();
    end

    // Backpressure: result held for 10 cycles, then next op accepted right after release.
    start_op(2'b01, 32'd100, 32'd7);
    wait_out(lat);
    check("hold_lat", lat, 33);
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.res !== 32'd14 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) seen++;
    end
    check("hold_stable_errs", seen, 0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("release_in_ready",  {31'd0, bus.in_ready},  32'd1);
    bus.op = 2'b11; bus.src1 = 32'd100; bus.src2 = 32'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("next_accepted", {31'd0, bus.in_ready}, 32'd0);
    wait_out(lat);
    check("next_res", bus.res, 32'd2);
    consume();

    // Leave a recognisable result behind, then flush in cycle 10 of CALC.
    start_op(2'b00, 32'd5, 32'd0);
    wait_out(lat);
    consume();
    start_op(2'b01, 32'd1000, 32'd3);
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("flush_no_result", seen, 0);
    check("flush_res_kept",  bus.res, 32'hFFFFFFFF);
    check("flush_dz_kept",   {31'd0, bus.div_zero}, 32'd1);

    // Flush in the same cycle as in_valid: nothing is accepted.
    bus.op = 2'b10; bus.src1 = 32'd9; bus.src2 = 32'd0; bus.in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_beats_valid_rdy", {31'd0, bus.in_ready},  32'd1);
    check("flush_beats_valid_ov",  {31'd0, bus.out_valid}, 32'd0);

    // Reset mid-CALC returns every output to its reset value.
    start_op(2'b01, 32'd100, 32'd7);
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_res",       bus.res,                32'd0);
    check("midrst_div_zero",  {31'd0, bus.div_zero},  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    start_op(2'b00, 32'hFFFFFFF9, 32'd2);
    wait_out(lat);
    r = bus.res;
    check("post_rst_res", r, 32'hFFFFFFFD);
    check("post_rst_lat", lat, 33);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
